lc3_clock_controller: RTL

Sequences execution of the LC-3 core by generating a single-cycle clock-enable strobe (cpu_en) from the 50 MHz board clock. No derived clocks are used. Supports free-run at a selectable divided rate, debounced single-step from a push button, and halt on the core's HALT indication. It sits between the board switches and buttons and the core's enable input, replacing the standalone 1 Hz divider as the core's pacing source.

---
 rtl/lc3_clock_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lc3_clock_controller.sv
// ----------------------------------------------------------------------------
// lc3_clock_controller
//
// Paces the LC-3 core by issuing a single-cycle enable strobe (cpu_en) from
// the board clock. There are no derived clocks. The core can free-run at a
// selectable divided rate, single-step from a debounced push button, and
// stops on the core's HALT indication.
//
// Ports:
//   clk         board clock; all logic on posedge
//   reset       asynchronous, active-high; clears all state
//   run_sw      free-run switch (asynchronous level, synchronized here)
//   step_btn    single-step push button (asynchronous, bouncy, active-high)
//   rate_sel    run rate: 00 = 1 Hz, 01 = 10 Hz, 10 = 1 kHz, 11 = every cycle
//   cpu_halt    HALT executed by the core (synchronous to clk)
//   cpu_en      registered one-cycle enable strobe to the core
//   heartbeat   toggles on every cpu_en pulse
//   state       00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   step_count  number of cpu_en pulses issued, wraps FFFF -> 0000
// ----------------------------------------------------------------------------
module lc3_clock_controller #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DIV_WIDTH       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  rate_sel,
    input  logic        cpu_halt,
    output logic        cpu_en,
    output logic        heartbeat,
    output logic [1:0]  state,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [DIV_WIDTH-1:0] TC_1HZ  = DIV_WIDTH'(CLK_HZ - 1);
    localparam logic [DIV_WIDTH-1:0] TC_10HZ = DIV_WIDTH'(CLK_HZ / 10 - 1);
    localparam logic [DIV_WIDTH-1:0] TC_1KHZ = DIV_WIDTH'(CLK_HZ / 1000 - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic       r_run_meta;
    logic       r_run_sync;
    logic       r_btn_meta;
    logic       r_btn_sync;
    logic [1:0] r_rate;
    logic [1:0] r_rate_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_meta  <= 1'b0;
            r_run_sync  <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_rate      <= '0;
            r_rate_prev <= '0;
        end else begin
            r_run_meta  <= run_sw;
            r_run_sync  <= r_run_meta;
            r_btn_meta  <= step_btn;
            r_btn_sync  <= r_btn_meta;
            r_rate      <= rate_sel;
            r_rate_prev <= r_rate;
        end
    end

    // ------------------------------------------------------------------
    // Step button debounce and press detection
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_deb_lvl;
    logic             r_deb_prev;
    logic             r_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_cnt  <= '0;
            r_deb_lvl  <= 1'b0;
            r_deb_prev <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            if (r_btn_sync == r_deb_lvl) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                // Level has disagreed for DEBOUNCE_CYCLES consecutive edges.
                r_deb_lvl <= r_btn_sync;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
            r_deb_prev <= r_deb_lvl;
            r_press    <= r_deb_lvl & ~r_deb_prev;
        end
    end

    // ------------------------------------------------------------------
    // Rate divider terminal count
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] w_tc;
    logic                 w_rate_chg;

    always_comb begin
        w_tc = '0;
        unique case (r_rate)
            2'b00: w_tc = TC_1HZ;
            2'b01: w_tc = TC_10HZ;
            2'b10: w_tc = TC_1KHZ;
            2'b11: w_tc = '0;
        endcase
    end

    assign w_rate_chg = (r_rate != r_rate_prev);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_cpu_en;
    logic                 r_heartbeat;
    logic [15:0]          r_step_count;
    logic                 w_div_hit;
    logic                 w_pulse;

    // A rate change restarts the count, so a stale counter value compared
    // against the new terminal count must not produce a pulse.
    assign w_div_hit = (r_div == w_tc) && !w_rate_chg;

    // Halt and run_sw=0 take priority over a divider wrap in RUN.
    assign w_pulse = (r_state == S_STEP) ||
                     ((r_state == S_RUN) && !cpu_halt && r_run_sync && w_div_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_cpu_en     <= 1'b0;
            r_heartbeat  <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_cpu_en <= w_pulse;
            if (w_pulse) begin
                r_step_count <= r_step_count + 16'd1;
                r_heartbeat  <= ~r_heartbeat;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (cpu_halt && r_run_sync) begin
                        r_state <= S_HALTED;
                    end else if (r_run_sync) begin
                        r_state <= S_RUN;
                    end else if (r_press) begin
                        r_state <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        r_state <= S_HALTED;
                        r_div   <= '0;
                    end else if (!r_run_sync) begin
                        r_state <= S_IDLE;
                        r_div   <= '0;
                    end else if (w_rate_chg || (r_div == w_tc)) begin
                        r_div <= '0;
                    end else begin
                        r_div <= r_div + DIV_WIDTH'(1);
                    end
                end
                S_STEP: begin
                    r_div   <= '0;
                    r_state <= r_run_sync ? S_RUN : S_IDLE;
                end
                S_HALTED: begin
                    r_div <= '0;
                    if (!r_run_sync) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cpu_en     = r_cpu_en;
    assign heartbeat  = r_heartbeat;
    assign state      = r_state;
    assign step_count = r_step_count;

endmodule
